// File: rtl/img_buf_pkg.sv
// Shared types and geometry for the image-buffer port arbiter.
package img_buf_pkg;

   localparam int IMG_CH    = 3;
   localparam int IMG_ROWS  = 8;
   localparam int IMG_COLS  = 8;
   localparam int IMG_DEPTH = IMG_CH * IMG_ROWS * IMG_COLS;

   typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, RD_DRAIN} arb_state_e;
   typedef enum logic {REQ_WR, REQ_RD} req_e;

endpackage

// File: rtl/img_buf_rd_lat_pipe.sv
// Delay line that tracks issued buffer reads until their data returns.
module img_buf_rd_lat_pipe
   import img_buf_pkg::*;
#(
   parameter int RD_LAT = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic issue_i,
   input  logic last_i,
   output logic valid_o,
   output logic last_o
);

   logic [RD_LAT-1:0] valid_q;
   logic [RD_LAT-1:0] last_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         last_q  <= '0;
      end else begin
         valid_q[0] <= issue_i;
         last_q[0]  <= last_i;
         for (int i = 1; i < RD_LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            last_q[i]  <= last_q[i-1];
         end
      end
   end

   assign valid_o = valid_q[RD_LAT-1];
   assign last_o  = last_q[RD_LAT-1];

endmodule

// File: rtl/img_buf_port_arbiter.sv
// Burst arbiter sharing the single-port image buffer between a writer and a reader.
// Define WR_PRIORITY_EN for fixed writer priority; otherwise round-robin on contention.
module img_buf_port_arbiter
   import img_buf_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = IMG_DEPTH,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_base,
   input  logic [ADDR_W-1:0] wr_len,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_gnt,
   output logic              wr_ack,
   output logic              wr_done,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_base,
   input  logic [ADDR_W-1:0] rd_len,
   output logic              rd_gnt,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   // state    | meaning
   // IDLE     | no burst; requests evaluated here only
   // WR_BURST | one write word per cycle until the length counter hits zero
   // RD_BURST | one read address per cycle until the length counter hits zero
   // RD_DRAIN | waiting for the last read word to come back

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   arb_state_e        state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              wr_gnt_q, wr_ack_q, wr_done_q, rd_gnt_q;
   logic              mem_en_q, mem_we_q, busy_q;
   logic              wr_ok, rd_ok, pick_wr, pick_rd, rd_last_issue;

   assign wr_ok = wr_req && (wr_base <= LAST_ADDR);
   assign rd_ok = rd_req && (rd_base <= LAST_ADDR);

`ifdef WR_PRIORITY_EN
   assign pick_wr = wr_ok;
`else
   req_e last_gnt_q;
   assign pick_wr = wr_ok && (!rd_ok || (last_gnt_q == REQ_RD));
`endif
   assign pick_rd = rd_ok && !pick_wr;

   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mem_addr_q <= '0;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         wr_gnt_q   <= 1'b0;
         wr_ack_q   <= 1'b0;
         wr_done_q  <= 1'b0;
         rd_gnt_q   <= 1'b0;
         busy_q     <= 1'b0;
`ifndef WR_PRIORITY_EN
         last_gnt_q <= REQ_RD;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_wr || pick_rd) begin
                  state_q    <= pick_wr ? WR_BURST : RD_BURST;
                  cnt_q      <= pick_wr ? wr_len : rd_len;
                  mem_addr_q <= pick_wr ? wr_base : rd_base;
                  mem_en_q   <= 1'b1;
                  mem_we_q   <= pick_wr;
                  wr_gnt_q   <= pick_wr;
                  wr_ack_q   <= pick_wr;
                  wr_done_q  <= pick_wr && (wr_len == '0);
                  rd_gnt_q   <= pick_rd;
                  busy_q     <= 1'b1;
`ifndef WR_PRIORITY_EN
                  last_gnt_q <= pick_wr ? REQ_WR : REQ_RD;
`endif
               end
            end
            WR_BURST: begin
               if (cnt_q == '0) begin
                  state_q    <= IDLE;
                  mem_addr_q <= '0;
                  mem_en_q   <= 1'b0;
                  mem_we_q   <= 1'b0;
                  wr_gnt_q   <= 1'b0;
                  wr_ack_q   <= 1'b0;
                  wr_done_q  <= 1'b0;
                  busy_q     <= 1'b0;
               end else begin
                  cnt_q      <= cnt_q - 1'b1;
                  mem_addr_q <= addr_inc(mem_addr_q);
                  wr_done_q  <= (cnt_q == ADDR_W'(1));
               end
            end
            RD_BURST: begin
               if (cnt_q == '0) begin
                  state_q    <= RD_DRAIN;
                  mem_addr_q <= '0;
                  mem_en_q   <= 1'b0;
                  rd_gnt_q   <= 1'b0;
               end else begin
                  cnt_q      <= cnt_q - 1'b1;
                  mem_addr_q <= addr_inc(mem_addr_q);
               end
            end
            RD_DRAIN: begin
               // rd_done is registered, so busy clears the cycle after it
               if (rd_done) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rd_last_issue = rd_gnt_q && (cnt_q == '0);

   img_buf_rd_lat_pipe #(.RD_LAT(RD_LAT)) u_rd_lat_pipe (
      .clk     (clk),
      .reset   (reset),
      .issue_i (rd_gnt_q),
      .last_i  (rd_last_issue),
      .valid_o (rd_valid),
      .last_o  (rd_done)
   );

   assign wr_gnt    = wr_gnt_q;
   assign wr_ack    = wr_ack_q;
   assign wr_done   = wr_done_q;
   assign rd_gnt    = rd_gnt_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign busy      = busy_q;
   assign mem_wdata = mem_we_q ? wr_data : '0;
   assign rd_data   = mem_rdata;

endmodule

// File: tb/tb_img_buf_port_arbiter.sv
// Self-checking bench for img_buf_port_arbiter: directed table, reset corner, random bursts.
module tb_img_buf_port_arbiter;
   import img_buf_pkg::*;

   localparam int RD_LAT = 2;
   localparam int DEPTH  = IMG_DEPTH;
   localparam int SCHED  = 1024;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_req, rd_req;
   logic [7:0] wr_base, wr_len, wr_data, rd_base, rd_len;
   logic       wr_gnt, wr_ack, wr_done, rd_gnt, rd_valid, rd_done;
   logic       mem_en, mem_we, busy;
   logic [7:0] rd_data, mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   img_buf_port_arbiter #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(reset),
      .wr_req(wr_req), .wr_base(wr_base), .wr_len(wr_len), .wr_data(wr_data),
      .wr_gnt(wr_gnt), .wr_ack(wr_ack), .wr_done(wr_done),
      .rd_req(rd_req), .rd_base(rd_base), .rd_len(rd_len),
      .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   // behavioural single-port buffer with RD_LAT read latency
   logic [7:0] mem   [256];
   logic [7:0] rpipe [RD_LAT];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 11);
      end else if (mem_en && mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      rpipe[0] <= mem[mem_addr];
      for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign mem_rdata = rpipe[RD_LAT-1];

   wire [16:0] dut_v = {wr_gnt, wr_ack, wr_done, rd_gnt, rd_valid, rd_done,
                        mem_en, mem_we, busy, mem_addr};

   typedef struct {
      logic       wr_gnt, wr_ack, wr_done, rd_gnt, rd_valid, rd_done, mem_en, mem_we, busy;
      logic [7:0] addr, wdata, rdata;
   } cyc_t;

   typedef struct {
      bit dw, dr;
      int wb, wl, rb, rl;
      int first;
      int busy_n;
   } vec_t;

   cyc_t       sched  [SCHED];
   logic [7:0] shadow [DEPTH];
   int         errors = 0;
   int         checks = 0;
   int         last_win;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, want);
      end
   endtask

   function automatic logic [16:0] pack_exp(input cyc_t c);
      return {c.wr_gnt, c.wr_ack, c.wr_done, c.rd_gnt, c.rd_valid, c.rd_done,
              c.mem_en, c.mem_we, c.busy, c.addr};
   endfunction

   task automatic fill_shadow();
      for (int i = 0; i < DEPTH; i++) shadow[i] = 8'(i * 37 + 11);
   endtask

   task automatic put_wr(input int t, input int b, input int l, output int nxt);
      for (int k = 0; k <= l; k++) begin
         int c, a;
         c = t + k;
         a = (b + k) % DEPTH;
         sched[c].wr_gnt  = 1'b1;
         sched[c].wr_ack  = 1'b1;
         sched[c].mem_en  = 1'b1;
         sched[c].mem_we  = 1'b1;
         sched[c].busy    = 1'b1;
         sched[c].addr    = 8'(a);
         sched[c].wdata   = 8'($urandom);
         sched[c].wr_done = (k == l);
         shadow[a] = sched[c].wdata;
      end
      nxt = t + l + 2;
   endtask

   task automatic put_rd(input int t, input int b, input int l, output int nxt);
      for (int k = 0; k <= l; k++) begin
         int c, a;
         c = t + k;
         a = (b + k) % DEPTH;
         sched[c].rd_gnt = 1'b1;
         sched[c].mem_en = 1'b1;
         sched[c].busy   = 1'b1;
         sched[c].addr   = 8'(a);
         sched[c + RD_LAT].rd_valid = 1'b1;
         sched[c + RD_LAT].rd_done  = (k == l);
         sched[c + RD_LAT].rdata    = shadow[a];
         sched[c + RD_LAT].busy     = 1'b1;
      end
      nxt = t + l + RD_LAT + 2;
   endtask

   // Transaction-level plan: who wins, then each burst laid out back to back with one idle gap.
   task automatic plan(input bit dw, input bit dr, input int wb, input int wl,
                       input int rb, input int rl, output int n, output int ef);
      bit vw, vr, wr_first;
      int t;
      for (int i = 0; i < SCHED; i++) sched[i] = '{default: '0};
      vw = dw && (wb < DEPTH);
      vr = dr && (rb < DEPTH);
`ifdef WR_PRIORITY_EN
      wr_first = vw;
`else
      wr_first = vw && (!vr || last_win == 2);
`endif
      t  = 1;
      ef = 0;
      if (wr_first) begin
         ef = 1;
         put_wr(t, wb, wl, t);
         if (vr) begin put_rd(t, rb, rl, t); last_win = 2; end
         else last_win = 1;
      end else if (vr) begin
         ef = 2;
         put_rd(t, rb, rl, t);
         if (vw) begin put_wr(t, wb, wl, t); last_win = 1; end
         else last_win = 2;
      end
      n = t + 2;
   endtask

   task automatic run(input bit dw, input bit dr, input int wb, input int wl,
                      input int rb, input int rl, output int first, output int busy_n);
      int n, ef;
      plan(dw, dr, wb, wl, rb, rl, n, ef);
      first  = 0;
      busy_n = 0;
      wr_base = 8'(wb); wr_len = 8'(wl);
      rd_base = 8'(rb); rd_len = 8'(rl);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check($sformatf("outputs cyc%0d", i), 32'(dut_v), 32'(pack_exp(sched[i])));
         if (sched[i].rd_valid)
            check($sformatf("rd_data cyc%0d", i), 32'(rd_data), 32'(sched[i].rdata));
         wr_data = sched[i].mem_we ? sched[i].wdata : 8'($urandom);
         #1;
         check($sformatf("mem_wdata cyc%0d", i), 32'(mem_wdata),
               32'(sched[i].mem_we ? sched[i].wdata : 8'h00));
         if (busy) busy_n++;
         if (first == 0 && wr_gnt) first = 1;
         else if (first == 0 && rd_gnt) first = 2;
         if (i == 0) begin wr_req = dw; rd_req = dr; end
         if (wr_gnt) begin wr_req = 1'b0; wr_base = 8'($urandom); wr_len = 8'($urandom); end
         if (rd_gnt) begin rd_req = 1'b0; rd_base = 8'($urandom); rd_len = 8'($urandom); end
      end
      wr_req = 1'b0;
      rd_req = 1'b0;
      check("first grant vs model", 32'(first), 32'(ef));
   endtask

   vec_t tbl [10];

   initial begin
      int f, b;
      reset = 1'b1;
      wr_req = 1'b0; rd_req = 1'b0;
      wr_base = '0; wr_len = '0; wr_data = '0; rd_base = '0; rd_len = '0;
      last_win = 2;
      fill_shadow();

      //            dw dr  wb  wl   rb  rl  first busy
      tbl[0] = '{1, 0,   0, 191,   0,   0, 1, 192};
      tbl[1] = '{0, 1,   0,   0,   0, 191, 2, 194};
      tbl[2] = '{0, 1,   0,   0, 190,   3, 2,   6};
      tbl[3] = '{1, 1,  10,   4,  10,   4, 1,  12};
      tbl[4] = '{1, 0, 191,   1,   0,   0, 1,   2};
`ifdef WR_PRIORITY_EN
      tbl[5] = '{1, 1,   5,   0, 191,   1, 1,   5};
`else
      tbl[5] = '{1, 1,   5,   0, 191,   1, 2,   5};
`endif
      tbl[6] = '{1, 0, 200,   3,   0,   0, 0,   0};
      tbl[7] = '{0, 1,   0,   0, 192,   0, 0,   0};
      tbl[8] = '{1, 1, 250,   2, 100,   2, 2,   5};
      tbl[9] = '{1, 0, 191,   0,   0,   0, 1,   1};

      repeat (2) @(negedge clk);
      check("outputs in reset", 32'(dut_v), 32'h0);
      reset = 1'b0;
      @(negedge clk);
      check("outputs after reset", 32'(dut_v), 32'h0);

      for (int v = 0; v < 10; v++) begin
         run(tbl[v].dw, tbl[v].dr, tbl[v].wb, tbl[v].wl, tbl[v].rb, tbl[v].rl, f, b);
         check($sformatf("vec%0d first grant", v), 32'(f), 32'(tbl[v].first));
         check($sformatf("vec%0d busy cycles", v), 32'(b), 32'(tbl[v].busy_n));
      end

      // reset in the third cycle of a read burst
      @(negedge clk);
      rd_base = 8'd0; rd_len = 8'd9; rd_req = 1'b1;
      @(negedge clk);
      check("rst-seq grant", 32'(rd_gnt), 32'h1);
      rd_req = 1'b0;
      repeat (2) @(negedge clk);
      check("rst-seq addr before reset", 32'(mem_addr), 32'h2);
      reset = 1'b1;
      #1;
      check("rst-seq async clear", 32'(dut_v), 32'h0);
      check("rst-seq mem_wdata", 32'(mem_wdata), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      fill_shadow();
      last_win = 2;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("rst-seq quiet cyc%0d", i), 32'(dut_v), 32'h0);
      end

      for (int it = 0; it < 40; it++) begin
         bit dw, dr;
         int wb, wl, rb, rl;
         dw = 1'($urandom_range(0, 1));
         dr = 1'($urandom_range(0, 1));
         wb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(192, 255)) : int'($urandom_range(0, 191));
         rb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(192, 255)) : int'($urandom_range(0, 191));
         wl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
         rl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
         run(dw, dr, wb, wl, rb, rl, f, b);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
